// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU.
// ALU op codes, opcode and funct3 encodings.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_CPYB = 4'd10;
  localparam logic [3:0] ALU_XXX  = 4'd15;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // funct3 table shared by R-type and I-arith
  function automatic logic [3:0] arith_op(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_XXX;
    case (f3)
      F3_ADDSUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:    op = ALU_SLL;
      F3_SLT:    op = ALU_SLT;
      F3_SLTU:   op = ALU_SLTU;
      F3_XOR:    op = ALU_XOR;
      F3_SR:     op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:     op = ALU_OR;
      F3_AND:    op = ALU_AND;
      default:   op = ALU_XXX;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU-op decoder: opcode/funct3/instr[30] to a 4-bit ALU op.
// Purely combinational.
module alu_dec
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct,
  input  logic       add_rshift_type,
  output logic [3:0] ALUop
);

  logic w_is_r;
  logic w_is_i;
  logic w_is_addr;
  logic w_i_alt;

  assign w_is_r = (opcode == OPC_RTYPE);
  assign w_is_i = (opcode == OPC_ITYPE);

  assign w_is_addr = (opcode == OPC_AUIPC)
                  || (opcode == OPC_JAL)
                  || (opcode == OPC_JALR)
                  || (opcode == OPC_BRANCH)
                  || (opcode == OPC_LOAD)
                  || (opcode == OPC_STORE);

  // instr[30] is immediate data for ADDI, so only SRAI honours it
  assign w_i_alt = add_rshift_type
                && (funct == F3_SR);

  always_comb begin
    ALUop = ALU_XXX;
    unique case (1'b1)
      w_is_r:
        ALUop = arith_op(funct, add_rshift_type);
      w_is_i:
        ALUop = arith_op(funct, w_i_alt);
      (opcode == OPC_LUI):
        ALUop = ALU_CPYB;
      w_is_addr:
        ALUop = ALU_ADD;
      default:
        ALUop = ALU_XXX;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with decoder and registered result.
// Out is same-cycle combinational; Out_q is Out delayed one edge.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct,
  input  logic            add_rshift_type,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [3:0]      ALUop,
  output logic [XLEN-1:0] Out,
  output logic [XLEN-1:0] Out_q
);

  logic [4:0]      w_shamt;
  logic            w_lt;
  logic            w_ltu;
  logic [XLEN-1:0] w_zero;
  logic [XLEN-1:0] r_out;

  alu_dec u_dec (
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .ALUop           (ALUop)
  );

  assign w_shamt = B[4:0];
  assign w_lt    = $signed(A) < $signed(B);
  assign w_ltu   = A < B;
  assign w_zero  = '0;

  always_comb begin
    Out = w_zero;
    case (ALUop)
      ALU_ADD:  Out = A + B;
      ALU_SUB:  Out = A - B;
      ALU_AND:  Out = A & B;
      ALU_OR:   Out = A | B;
      ALU_XOR:  Out = A ^ B;
      ALU_SLT:  Out = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLTU: Out = {{(XLEN-1){1'b0}}, w_ltu};
      ALU_SLL:  Out = A << w_shamt;
      ALU_SRA:  Out = $unsigned($signed(A) >>> w_shamt);
      ALU_SRL:  Out = A >> w_shamt;
      ALU_CPYB: Out = B;
      default:  Out = w_zero;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_out <= '0;
    end else begin
      r_out <= Out;
    end
  end

  assign Out_q = r_out;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit.
// Expected results are queued on drive and popped on sample.
module tb_alu_exec_unit;

  logic        Clock;
  logic        Reset;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] Out_q;

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  alu_exec_unit #(.XLEN(32)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .A               (A),
    .B               (B),
    .ALUop           (ALUop),
    .Out             (Out),
    .Out_q           (Out_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic apply(
    input string       tag,
    input logic [6:0]  op,
    input logic [2:0]  f,
    input logic        ars,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  e_op,
    input logic [31:0] e_res
  );
    exp_t e;
    opcode          = op;
    funct           = f;
    add_rshift_type = ars;
    A               = a;
    B               = b;
    e.tag = tag;
    e.op  = e_op;
    e.res = e_res;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    vectors++;
    assert (ALUop === e.op) else begin
      miscompares++;
      $error("FAIL %s ALUop: got %0d expected %0d",
             e.tag, ALUop, e.op);
    end
    vectors++;
    assert (Out === e.res) else begin
      miscompares++;
      $error("FAIL %s Out: got %h expected %h",
             e.tag, Out, e.res);
    end
  endtask

  task automatic check_q(
    input string       tag,
    input logic [31:0] e_q
  );
    vectors++;
    assert (Out_q === e_q) else begin
      miscompares++;
      $error("FAIL %s Out_q: got %h expected %h",
             tag, Out_q, e_q);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    opcode      = 7'b0;
    funct       = 3'b0;
    add_rshift_type = 1'b0;
    A           = '0;
    B           = '0;

    // registered path and reset behaviour
    @(posedge Clock); #1;
    apply("rst_add", 7'b0110011, 3'b000, 1'b0,
          32'd5, 32'd7, 4'd0, 32'd12);
    @(posedge Clock); #1;
    check_q("q_reset", 32'd0);
    Reset = 1'b0;
    #1;
    check_q("q_rel_pre", 32'd0);
    @(posedge Clock); #1;
    check_q("q_first", 32'd12);
    apply("r_sub", 7'b0110011, 3'b000, 1'b1,
          32'd5, 32'd7, 4'd1, 32'hFFFFFFFE);
    check_q("q_hold", 32'd12);
    @(posedge Clock); #1;
    check_q("q_sub", 32'hFFFFFFFE);
    Reset = 1'b1;
    apply("sub_in_rst", 7'b0110011, 3'b000, 1'b1,
          32'd5, 32'd7, 4'd1, 32'hFFFFFFFE);
    check_q("q_rst_pre", 32'hFFFFFFFE);
    @(posedge Clock); #1;
    check_q("q_rst_edge", 32'd0);
    Reset = 1'b0;

    // combinational decode and ALU
    apply("srai", 7'b0010011, 3'b101, 1'b1,
          32'h80000000, 32'd4, 4'd8, 32'hF8000000);
    apply("srli", 7'b0010011, 3'b101, 1'b0,
          32'h80000000, 32'd4, 4'd9, 32'h08000000);
    apply("sra31", 7'b0110011, 3'b101, 1'b1,
          32'h80000000, 32'hFFFFFFFF, 4'd8, 32'hFFFFFFFF);
    apply("slt", 7'b0110011, 3'b010, 1'b0,
          32'hFFFFFFFF, 32'd1, 4'd5, 32'd1);
    apply("sltu", 7'b0110011, 3'b011, 1'b0,
          32'hFFFFFFFF, 32'd1, 4'd6, 32'd0);
    apply("slt_rev", 7'b0110011, 3'b010, 1'b0,
          32'd1, 32'hFFFFFFFF, 4'd5, 32'd0);
    apply("sltiu_rev", 7'b0010011, 3'b011, 1'b0,
          32'd1, 32'hFFFFFFFF, 4'd6, 32'd1);
    apply("addi_ars", 7'b0010011, 3'b000, 1'b1,
          32'd3, 32'hFFFFF800, 4'd0, 32'hFFFFF803);
    apply("add_wrap", 7'b0110011, 3'b000, 1'b0,
          32'hFFFFFFFF, 32'd2, 4'd0, 32'd1);
    apply("sll_hib", 7'b0110011, 3'b001, 1'b0,
          32'd1, 32'hFFFFFFE3, 4'd7, 32'd8);
    apply("xor", 7'b0110011, 3'b100, 1'b0,
          32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0);
    apply("ori_ars", 7'b0010011, 3'b110, 1'b1,
          32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 32'hFFF0FFF0);
    apply("and", 7'b0110011, 3'b111, 1'b0,
          32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000);
    apply("lui", 7'b0110111, 3'b101, 1'b1,
          32'hDEADBEEF, 32'h12345000, 4'd10, 32'h12345000);
    apply("auipc", 7'b0010111, 3'b011, 1'b1,
          32'h1000, 32'h2000, 4'd0, 32'h3000);
    apply("jal", 7'b1101111, 3'b111, 1'b0,
          32'd8, 32'd4, 4'd0, 32'd12);
    apply("jalr", 7'b1100111, 3'b000, 1'b1,
          32'd100, 32'hFFFFFFFC, 4'd0, 32'd96);
    apply("branch", 7'b1100011, 3'b001, 1'b1,
          32'd20, 32'd10, 4'd0, 32'd30);
    apply("load", 7'b0000011, 3'b010, 1'b0,
          32'h400, 32'h10, 4'd0, 32'h410);
    apply("store", 7'b0100011, 3'b010, 1'b1,
          32'd100, 32'd4, 4'd0, 32'd104);
    apply("unknown", 7'b1111111, 3'b000, 1'b0,
          32'h12345678, 32'h9ABCDEF0, 4'd15, 32'd0);
    apply("unk_zero", 7'b0000000, 3'b101, 1'b1,
          32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 32'd0);

    // registered copy follows a new result after release
    @(posedge Clock); #1;
    check_q("q_unknown", 32'd0);
    apply("q_src", 7'b0110011, 3'b100, 1'b0,
          32'hA5A5A5A5, 32'h0F0F0F0F, 4'd4, 32'hAAAAAAAA);
    @(posedge Clock); #1;
    check_q("q_xor", 32'hAAAAAAAA);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_drain: got %0d expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
